// File: rtl/ahb_lite_sram_slave_if.sv
// rtl/ahb_lite_sram_slave_if.sv - AHB-Lite bus signals between a master/interconnect and the SRAM slave
interface ahb_lite_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite slave with word-organised SRAM, wait states and ERROR response
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_lite_sram_slave_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);

    logic [2:0]            state;
    logic [3:0]            wait_cnt;
    logic                  wr_q;
    logic [2:0]            size_q;
    logic [1:0]            lane_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  illegal;
    logic [3:0]            byte_en;
    logic                  unused_htrans0;

    // Only states that present HREADYOUT=1 can take a new address phase.
    assign accept = bus.HSEL && bus.HREADY && bus.HTRANS[1] &&
                    (state == S_IDLE || state == S_DATA || state == S_ERR2);
    assign unused_htrans0 = bus.HTRANS[0];

    // Classify the incoming address phase: bad size, misalignment or out of range.
    always_comb begin
        illegal = 1'b0;
        if (bus.HSIZE > 3'b010)
            illegal = 1'b1;
        if (bus.HSIZE == 3'b001 && bus.HADDR[0])
            illegal = 1'b1;
        if (bus.HSIZE == 3'b010 && bus.HADDR[1:0] != 2'b00)
            illegal = 1'b1;
        if ({1'b0, bus.HADDR} >= MEM_BYTES)
            illegal = 1'b1;
    end

    // Byte lanes touched by the latched transfer.
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            3'b000:  byte_en = 4'b0001 << lane_q;
            3'b001:  byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Transfer sequencer: latches the address phase and steps through wait/data/error cycles.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            wr_q     <= 1'b0;
            size_q   <= 3'b000;
            lane_q   <= 2'b00;
            idx_q    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= S_DATA;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                S_ERR1: state <= S_ERR2;
                default: begin
                    if (accept) begin
                        wr_q   <= bus.HWRITE;
                        size_q <= bus.HSIZE;
                        lane_q <= bus.HADDR[1:0];
                        idx_q  <= bus.HADDR[IDX_W+1:2];
                        if (illegal) begin
                            state <= S_ERR1;
                        end else if (WAIT_STATES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Commit write lanes at the end of the completion cycle; reset abandons the write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == S_DATA && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
        end
    end

    assign bus.HREADYOUT = !(state == S_WAIT || state == S_ERR1);
    assign bus.HRESP     = (state == S_ERR1 || state == S_ERR2);
    assign bus.HRDATA    = (state == S_DATA && !wr_q) ? mem[idx_q] : '0;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - self-checking bench for ahb_lite_sram_slave with WAIT_STATES 0, 1 and 3
module tb_ahb_lite_sram_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       hsel;
    logic [31:0]      haddr;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [2:0]       hsize;
    logic [31:0]      hwdata;
    logic [2:0]       rdy;
    logic [2:0]       resp;
    logic [2:0][31:0] rdat;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.HSEL   = hsel[g];
        assign bus.HADDR  = haddr;
        assign bus.HTRANS = htrans;
        assign bus.HWRITE = hwrite;
        assign bus.HSIZE  = hsize;
        assign bus.HWDATA = hwdata;
        assign bus.HREADY = bus.HREADYOUT;
        assign rdy[g]     = bus.HREADYOUT;
        assign resp[g]    = bus.HRESP;
        assign rdat[g]    = bus.HRDATA;
        ahb_lite_sram_slave #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(WS)
        ) u_dut (
            .HCLK(clk),
            .HRESET(rst),
            .bus(bus.slave)
        );
    end

    int tests = 0;
    int fails = 0;
    bit [7:0] mb [3][1024];

    typedef struct {
        string       nm;
        bit          wr;
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] wd;
        logic [31:0] erd;
        bit          eerr;
        int          estall;
    } vec_t;
    vec_t vt[$];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
        int unsigned au = a;
        int unsigned sz = 1 << s;
        if (s > 3'd2) return 1'b0;
        if (au >= 32'd1024) return 1'b0;
        if (au % sz != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] w);
        int unsigned ba;
        for (int i = 0; i < (1 << s); i++) begin
            ba = a + i;
            mb[d][ba] = w[8*(ba % 4) +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        int unsigned base = a & 32'hFFFF_FFFC;
        return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic do_xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] wd, output logic [31:0] rd, output int stalls,
                           output bit resp_first, output bit resp_last);
        bit done = 1'b0;
        stalls = 0; rd = '0; resp_first = 1'b0; resp_last = 1'b0;
        @(negedge clk);
        hsel = 3'b000; hsel[d] = 1'b1;
        haddr = a; htrans = 2'b10; hwrite = wr; hsize = s;
        @(posedge clk);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            htrans = 2'b00; hsel = 3'b000; hwdata = wd;
            if (c == 0) resp_first = resp[d];
            if (rdy[d]) begin
                done = 1'b1; rd = rdat[d]; resp_last = resp[d];
            end else begin
                stalls++;
            end
            @(posedge clk);
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout dut%0d addr 0x%08h: no HREADYOUT within 40 cycles", d, a);
        end
    endtask

    task automatic run_checked(input string nm, input int d, input bit wr, input logic [31:0] a,
                               input logic [2:0] s, input logic [31:0] wd, input logic [31:0] erd,
                               input bit eerr, input int estall);
        logic [31:0] rd;
        int st;
        bit rf, rl;
        do_xfer(d, wr, a, s, wd, rd, st, rf, rl);
        check({nm, " rdata"}, rd, erd);
        check({nm, " stalls"}, st, estall);
        check({nm, " resp"}, {rf, rl}, {eerr, eerr});
    endtask

    initial begin
        logic [31:0] a, w, erd;
        logic [2:0]  s;
        bit          wr, lg;
        int          r;

        rst = 1'b1; hsel = 3'b000; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'b010; hwdata = '0;

        // Reset and idle behaviour on all three instances
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("reset hreadyout", rdy, 3'b111);
        check("reset hresp", resp, 3'b000);
        check("reset hrdata", rdat[0] | rdat[1] | rdat[2], 32'h0);
        rst = 1'b0; hsel = 3'b111; htrans = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle hreadyout", rdy, 3'b111);
            check("idle hresp", resp, 3'b000);
            check("idle hrdata", rdat[0] | rdat[1] | rdat[2], 32'h0);
        end
        hsel = 3'b000;
        @(posedge clk);

        // Directed vectors on the WAIT_STATES=1 instance
        vt.push_back('{"word write 0x10", 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0, 1});
        vt.push_back('{"word read 0x10", 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0, 1});
        vt.push_back('{"clear 0x20", 1, 32'h20, 3'b010, 32'h00000000, 32'h0, 0, 1});
        vt.push_back('{"byte write 0x21", 1, 32'h21, 3'b000, 32'h0000AB00, 32'h0, 0, 1});
        vt.push_back('{"half write 0x22", 1, 32'h22, 3'b001, 32'h12340000, 32'h0, 0, 1});
        vt.push_back('{"lane read 0x20", 0, 32'h20, 3'b010, 32'h0, 32'h1234AB00, 0, 1});
        vt.push_back('{"word write 0x00", 1, 32'h00, 3'b010, 32'hCAFEF00D, 32'h0, 0, 1});
        vt.push_back('{"misaligned read 0x03", 0, 32'h03, 3'b010, 32'h0, 32'h0, 1, 1});
        vt.push_back('{"out of range write 0x400", 1, 32'h400, 3'b010, 32'hBAD0BAD0, 32'h0, 1, 1});
        vt.push_back('{"misaligned half 0x11", 1, 32'h11, 3'b001, 32'hFFFFFFFF, 32'h0, 1, 1});
        vt.push_back('{"bad size 0x10", 0, 32'h10, 3'b011, 32'h0, 32'h0, 1, 1});
        vt.push_back('{"read back 0x00", 0, 32'h00, 3'b010, 32'h0, 32'hCAFEF00D, 0, 1});
        vt.push_back('{"read back 0x10", 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0, 1});
        for (int i = 0; i < vt.size(); i++) begin
            run_checked(vt[i].nm, 1, vt[i].wr, vt[i].a, vt[i].s, vt[i].wd,
                        vt[i].erd, vt[i].eerr, vt[i].estall);
            if (vt[i].wr && legal(vt[i].a, vt[i].s))
                model_write(1, vt[i].a, vt[i].s, vt[i].wd);
        end

        // Back-to-back write then read with no wait states
        @(negedge clk);
        hsel = 3'b001; haddr = 32'h08; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk);
        @(negedge clk);
        check("b2b write hreadyout", rdy[0], 1'b1);
        check("b2b write hrdata", rdat[0], 32'h0);
        hwdata = 32'h55AA55AA;
        haddr = 32'h08; htrans = 2'b10; hwrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b read hreadyout", rdy[0], 1'b1);
        check("b2b read hresp", resp[0], 1'b0);
        check("b2b read hrdata", rdat[0], 32'h55AA55AA);
        htrans = 2'b00; hsel = 3'b000;
        @(posedge clk);
        model_write(0, 32'h08, 3'b010, 32'h55AA55AA);

        // Reset during the second wait cycle of a write (WAIT_STATES=3)
        run_checked("midrst prefill 0x30", 2, 1, 32'h30, 3'b010, 32'h11111111, 32'h0, 0, 3);
        model_write(2, 32'h30, 3'b010, 32'h11111111);
        @(negedge clk);
        hsel = 3'b100; haddr = 32'h30; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk);
        @(negedge clk);
        htrans = 2'b00; hsel = 3'b000; hwdata = 32'hFFFFFFFF;
        check("midrst wait1 hreadyout", rdy[2], 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("midrst wait2 hreadyout", rdy[2], 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst after hreadyout", rdy[2], 1'b1);
        check("midrst after hresp", resp[2], 1'b0);
        @(posedge clk);
        run_checked("midrst readback 0x30", 2, 0, 32'h30, 3'b010, 32'h0, 32'h11111111, 0, 3);

        // Randomized transfers against the byte-addressed reference model
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 16; k++) begin
                a = 32'(k * 4);
                w = $urandom;
                run_checked("rand prefill", d, 1, a, 3'b010, w, 32'h0, 0, ws_of(d));
                model_write(d, a, 3'b010, w);
            end
            for (int k = 0; k < 120; k++) begin
                r = $urandom_range(0, 9);
                s = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
                r = $urandom_range(0, 9);
                a = (r == 0) ? 32'h400 + $urandom_range(0, 15) : (r == 1) ? $urandom : $urandom_range(0, 63);
                wr = 1'($urandom_range(0, 1));
                w = $urandom;
                lg = legal(a, s);
                erd = (!wr && lg) ? model_read(d, a) : 32'h0;
                run_checked($sformatf("rand dut%0d %s a=%08h s=%0d", d, wr ? "wr" : "rd", a, s),
                            d, wr, a, s, w, erd, !lg, lg ? ws_of(d) : 1);
                if (wr && lg)
                    model_write(d, a, s, w);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder (slave) backed by a word-organised on-chip SRAM array.
- Sits on the bus opposite the master; its HREADYOUT, HRESP and HRDATA are the signals the bus monitor checks.
- Supports programmable wait states and byte, halfword and word transfers.
- Returns the two-cycle ERROR response for illegal transfers.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width (fixed 32; other values unsupported).
- MEM_DEPTH, 256, number of 32-bit words; byte address range 0 .. 4*MEM_DEPTH-1.
- WAIT_STATES, 1, HREADYOUT-low cycles inserted per OKAY data phase (0..15).

Ports:
- HCLK  in  1  bus clock, all logic on rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HWDATA  in  DATA_WIDTH  write data, valid in data phase.
- HREADY  in  1  bus-level ready (mux of all HREADYOUTs).
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  DATA_WIDTH  read data.

Behaviour:
- Reset (HRESET=1 at a rising edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0. Any pending data phase is abandoned and no write is committed. SRAM contents are not cleared.
- Address phase accepted when HSEL && HREADY && HTRANS[1]. On acceptance, latch HADDR, HWRITE, HSIZE.
- IDLE/BUSY with HSEL=1, or HSEL=0: no transfer. Stay/return to IDLE with HREADYOUT=1, HRESP=0.
- Error check at acceptance. Any of the following is an error:
  - HSIZE > 3'b010
  - halfword with HADDR[0]=1
  - word with HADDR[1:0]!=0
  - HADDR >= 4*MEM_DEPTH
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accepted legal transfer with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
    - Accepted legal transfer with WAIT_STATES=0 -> DATA.
    - Accepted illegal transfer -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Decrement counter; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; completion cycle.
    - Write: merge HWDATA byte lanes selected by latched HSIZE/HADDR[1:0] into the addressed word at end of cycle.
    - Read: HRDATA = addressed word, full 32 bits (master selects lanes).
    - Same-cycle new accepted address phase -> WAIT/DATA/ERR1 per its own rules, back-to-back with no bubble. Otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always -> ERR2. Bus inputs ignored (HREADY low).
  - ERR2: HREADYOUT=1, HRESP=1. No memory access. A new address phase may be accepted -> next state per rules, else IDLE.
- HRDATA outside a read completion cycle: 0.
- Read data is combinational from the array at the latched word address. A read whose data phase immediately follows a write to the same word returns the newly written value.
- Errored writes never modify memory. Errored reads return HRDATA=0.
- HRESP is never 1 while state is IDLE, WAIT or DATA.
- HREADYOUT=0 occurs only in WAIT or ERR1. Latched address/control stay stable while HREADYOUT=0.
- HBURST is not used. Bursts are handled as independent SEQ beats, each with full WAIT_STATES.

Test Plan:
- Reset/idle: HRESET=1 for 2 cycles, then HTRANS=IDLE with HSEL=1 -> HREADYOUT=1, HRESP=0, HRDATA=0 throughout.
- Word write/read, WAIT_STATES=1: write 0xDEADBEEF @0x10, then read @0x10 -> each data phase shows exactly 1 HREADYOUT=0 cycle; read returns 0xDEADBEEF.
- Byte/halfword lanes: word @0x20 = 0x00000000, write byte 0xAB @0x21 and halfword 0x1234 @0x22 -> read @0x20 returns 0x1234AB00.
- Errors: word read @0x03, then write @0x400 with MEM_DEPTH=256 -> each gives HREADYOUT 0 then 1 with HRESP=1 on both cycles. Word 0x100 (byte 0x400) is unchanged and @0x00 still reads its prior value.
- Back-to-back, WAIT_STATES=0: NONSEQ write 0x55AA55AA @0x08 followed immediately by read @0x08 -> zero stall cycles; read data 0x55AA55AA in the next cycle.
- Reset mid-transfer: WAIT_STATES=3, assert HRESET during the second WAIT cycle of a write of 0xFFFFFFFF @0x30 (prior value 0x11111111) -> next cycle HREADYOUT=1, HRESP=0; a later read @0x30 returns 0x11111111.
